lcd_bus_phy: RTL
================

# lcd_bus_phy

HD44780-class LCD bus timing engine sitting directly downstream of the character/command sequencer. Accepts whole-byte (or init-only single-nibble) writes over a valid/ready handshake, splits them into 4-bit transfers, and generates RS/D setup, E pulse width, hold and post-command execution delays. Frees the sequencer from cycle-counting and replaces its free-running E strobe with spec-compliant bus timing.

## Interface
- `SETUP_CYC`, 2: cycles RS/RW/D stable before E rises (≥1).
- `E_HIGH_CYC`, 12: E high width in cycles (≥1).
- `HOLD_CYC`, 2: cycles RS/D held after E falls (≥1).
- `CMD_WAIT_CYC`, 2000: post-byte execution wait (~40 µs @50 MHz).
- `LONG_WAIT_CYC`, 82000: wait after clear/home and nibble-only writes (~1.64 ms).
- `WAIT_W`, 17: counter width; must hold `LONG_WAIT_CYC`.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: sequencer request.
- `in_ready` out 1: high only in IDLE; transfer accepted on `in_valid & in_ready` edge.
- `in_rs` in 1: 0 = command, 1 = data.
- `in_nibble` in 1: 1 = send only `in_data[7:4]` (init-phase 8-bit-mode commands).
- `in_data` in 8: byte to write.
- `lcd_rs` out 1, `lcd_rw` out 1, `lcd_e` out 1.
- `lcd_d_out` out 4: D7..D4.
- `lcd_d_oe` out 1: 1 = PHY drives D bus.
- `lcd_d_in` in 4: D7..D4 readback (used only with busy polling).
- `busy` out 1: inverse of `in_ready`.

## Operation
- Reset values: `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_d_out`=0, `lcd_d_oe`=1, `in_ready`=1, `busy`=0; FSM → IDLE.
- States: IDLE → SETUP → E_HI → HOLD → (second nibble: SETUP) → WAIT → IDLE.
- On accept: latch rs/data/nibble flag; drive `lcd_rs`, `lcd_d_out`=data[7:4] in SETUP. After HOLD of high nibble: if byte, drive data[3:0] and repeat SETUP/E_HI/HOLD; if nibble-only, go to WAIT.
- WAIT length: `LONG_WAIT_CYC` if nibble-only, or `in_rs`=0 and data ∈ {0x01, 0x02, 0x03}; else `CMD_WAIT_CYC`.
- `lcd_rs`/`lcd_d_out` keep last value after transfer until next accept.
- `in_valid` ignored outside IDLE; inputs need not be held after accept.
- Reset mid-transfer: E falls on the reset edge; no completion of pending nibble; `in_ready` high the next cycle.

## Timing
- One nibble = `SETUP_CYC + E_HIGH_CYC + HOLD_CYC` cycles, E high for exactly `E_HIGH_CYC`.
- Byte: accept edge k → `in_ready` high after edge k + 2·(S+E+H) + wait.
- Nibble-only: k + (S+E+H) + `LONG_WAIT_CYC`.
- Back-to-back: new accept possible on first IDLE cycle; no extra bubble.

## Configuration
- `LCD_BUSY_POLL_EN` defined: byte writes replace WAIT with POLL: `lcd_d_oe`=0, `lcd_rw`=1, `lcd_rs`=0, two nibble read cycles; busy flag = `lcd_d_in[3]` sampled on last E_HI cycle of first nibble; repeat until 0; timeout after `LONG_WAIT_CYC` cycles exits anyway. `lcd_rw`=0/`lcd_d_oe`=1 restored before IDLE. Nibble-only writes still use fixed `LONG_WAIT_CYC`.
- Undefined: `lcd_rw` constant 0, `lcd_d_oe` constant 1, `lcd_d_in` unused; fixed waits only.

## Structure
- Shared package `lcd_pkg`: FSM state encoding, command constants (CLEAR=0x01, HOME=0x02/0x03), default timing values.
- One sub-module `lcd_delay_timer`: loadable `WAIT_W`-bit down-counter with `done` pulse, reused for setup/E/hold/wait phases.

## Test plan
Params S=2, E=4, H=2, CMD_WAIT=10, LONG_WAIT=50.
- Reset: `rst` 1 for 3 cycles → all outputs at reset values, `in_ready`=1.
- Data write rs=1, 0x48 at edge k → `lcd_d_out`=0x4 with E high k+3..k+6, 0x8 with E high k+11..k+14, `lcd_rs`=1, `in_ready` high at k+26.
- Command 0x01 → LONG_WAIT applied, `in_ready` high at k+66; 0x28 → k+26.
- Nibble-only 0x30 → single E pulse, D=0x3, `in_ready` at k+58.
- `rst` asserted during E_HI of second nibble → E low after that edge, `in_ready`=1 next cycle, fresh write proceeds normally.
- With `LCD_BUSY_POLL_EN`: `lcd_d_in[3]`=1 for 3 polls then 0 → exactly 4 read pairs, `lcd_rw`=1/`lcd_d_oe`=0 during poll; held 1 → exits after 50 cycles.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_bus_phy shared package
// FSM states, HD44780 command codes and default bus timing
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_E_HI,
    ST_HOLD,
    ST_WAIT
  } state_t;

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;

  localparam int SETUP_CYC_DEF     = 2;
  localparam int E_HIGH_CYC_DEF    = 12;
  localparam int HOLD_CYC_DEF      = 2;
  localparam int CMD_WAIT_CYC_DEF  = 2000;
  localparam int LONG_WAIT_CYC_DEF = 82000;
  localparam int WAIT_W_DEF        = 17;

  // clear/home commands need the long execution wait
  function automatic logic is_long_cmd(
    input logic       rs,
    input logic [7:0] data
  );
    return !rs && (data == CMD_CLEAR ||
                   data == CMD_HOME  ||
                   data == CMD_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_bus_phy_if.sv
// lcd_bus_phy bundle: sequencer handshake plus LCD pads
// master = sequencer/pad side, slave = the PHY
interface lcd_bus_phy_if;

  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic       in_nibble;
  logic [7:0] in_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [3:0] lcd_d_out;
  logic       lcd_d_oe;
  logic [3:0] lcd_d_in;
  logic       busy;

  modport master (
    output in_valid, in_rs, in_nibble, in_data, lcd_d_in,
    input  in_ready, busy, lcd_rs, lcd_rw, lcd_e,
    input  lcd_d_out, lcd_d_oe
  );

  modport slave (
    input  in_valid, in_rs, in_nibble, in_data, lcd_d_in,
    output in_ready, busy, lcd_rs, lcd_rw, lcd_e,
    output lcd_d_out, lcd_d_oe
  );

endinterface

// File: rtl/lcd_delay_timer.sv
// lcd_bus_phy phase timer
// loadable down-counter; done while the count sits at zero
module lcd_delay_timer #(
  parameter int WAIT_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  output logic              done
);

  logic [WAIT_W-1:0] cnt;

  // count down to zero and park there until reloaded
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - WAIT_W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lcd_bus_phy.sv
// lcd_bus_phy: HD44780 4-bit bus timing engine
// LCD_BUSY_POLL_EN: replace post-byte wait with busy-flag polling
module lcd_bus_phy
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC     = SETUP_CYC_DEF,
  parameter int E_HIGH_CYC    = E_HIGH_CYC_DEF,
  parameter int HOLD_CYC      = HOLD_CYC_DEF,
  parameter int CMD_WAIT_CYC  = CMD_WAIT_CYC_DEF,
  parameter int LONG_WAIT_CYC = LONG_WAIT_CYC_DEF,
  parameter int WAIT_W        = WAIT_W_DEF
) (
  input logic          clk,
  input logic          rst,
  lcd_bus_phy_if.slave bus
);

  localparam logic [WAIT_W-1:0] T_SETUP = WAIT_W'(SETUP_CYC - 1);
  localparam logic [WAIT_W-1:0] T_E     = WAIT_W'(E_HIGH_CYC - 1);
  localparam logic [WAIT_W-1:0] T_HOLD  = WAIT_W'(HOLD_CYC - 1);
  localparam logic [WAIT_W-1:0] T_CMD   = WAIT_W'(CMD_WAIT_CYC - 1);
  localparam logic [WAIT_W-1:0] T_LONG  = WAIT_W'(LONG_WAIT_CYC - 1);

  state_t            state;
  logic              rs_q;
  logic              e_q;
  logic              ready_q;
  logic              lo_q;
  logic              nib_q;
  logic              long_q;
  logic [3:0]        d_q;
  logic [3:0]        lo_data;
  logic              t_load;
  logic              t_done;
  logic [WAIT_W-1:0] t_val;
  logic              more_nib;
  logic              poll_byte;

`ifdef LCD_BUSY_POLL_EN
  logic              rw_q;
  logic              oe_q;
  logic              rd_q;
  logic              pbusy_q;
  logic              poll_to;
  logic [WAIT_W-1:0] poll_cnt;

  assign more_nib  = !lo_q && (rd_q || !nib_q);
  assign poll_byte = !nib_q;
  assign poll_to   = rd_q && (poll_cnt == T_LONG);
  assign bus.lcd_rw   = rw_q;
  assign bus.lcd_d_oe = oe_q;
`else
  logic unused_d_in;

  assign more_nib    = !lo_q && !nib_q;
  assign poll_byte   = 1'b0;
  assign unused_d_in = ^bus.lcd_d_in;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_d_oe = 1'b1;
`endif

  assign bus.lcd_rs    = rs_q;
  assign bus.lcd_e     = e_q;
  assign bus.lcd_d_out = d_q;
  assign bus.in_ready  = ready_q;
  assign bus.busy      = ~ready_q;

  lcd_delay_timer #(
    .WAIT_W (WAIT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );

  // length of the phase entered on this edge
  always_comb begin
    t_load = 1'b0;
    t_val  = '0;
    unique case (state)
      ST_IDLE: begin
        t_load = bus.in_valid;
        t_val  = T_SETUP;
      end
      ST_SETUP: begin
        t_load = t_done;
        t_val  = T_E;
      end
      ST_E_HI: begin
        t_load = t_done;
        t_val  = T_HOLD;
      end
      ST_HOLD: begin
        t_load = t_done;
        if (more_nib || poll_byte)
          t_val = T_SETUP;
        else
          t_val = long_q ? T_LONG : T_CMD;
      end
      default: ;
    endcase
  end

  // bus sequencer: nibble phases, waits and pad registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      d_q     <= '0;
      ready_q <= 1'b1;
      lo_q    <= 1'b0;
      nib_q   <= 1'b0;
      long_q  <= 1'b0;
      lo_data <= '0;
`ifdef LCD_BUSY_POLL_EN
      rw_q     <= 1'b0;
      oe_q     <= 1'b1;
      rd_q     <= 1'b0;
      pbusy_q  <= 1'b0;
      poll_cnt <= '0;
`endif
    end
`ifdef LCD_BUSY_POLL_EN
    else if (poll_to) begin
      e_q     <= 1'b0;
      rw_q    <= 1'b0;
      oe_q    <= 1'b1;
      rd_q    <= 1'b0;
      lo_q    <= 1'b0;
      ready_q <= 1'b1;
      state   <= ST_IDLE;
    end
`endif
    else begin
`ifdef LCD_BUSY_POLL_EN
      if (rd_q)
        poll_cnt <= poll_cnt + WAIT_W'(1);
`endif
      unique case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            ready_q <= 1'b0;
            rs_q    <= bus.in_rs;
            d_q     <= bus.in_data[7:4];
            lo_data <= bus.in_data[3:0];
            nib_q   <= bus.in_nibble;
            long_q  <= bus.in_nibble |
                       is_long_cmd(bus.in_rs, bus.in_data);
            lo_q    <= 1'b0;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (t_done) begin
            e_q   <= 1'b1;
            state <= ST_E_HI;
          end
        end
        ST_E_HI: begin
          if (t_done) begin
            e_q   <= 1'b0;
            state <= ST_HOLD;
`ifdef LCD_BUSY_POLL_EN
            if (rd_q && !lo_q)
              pbusy_q <= bus.lcd_d_in[3];
`endif
          end
        end
        ST_HOLD: begin
          if (t_done) begin
            if (more_nib) begin
              lo_q  <= 1'b1;
              state <= ST_SETUP;
`ifdef LCD_BUSY_POLL_EN
              if (!rd_q)
                d_q <= lo_data;
`else
              d_q <= lo_data;
`endif
            end else begin
              lo_q <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
              if (nib_q) begin
                state <= ST_WAIT;
              end else if (!rd_q) begin
                rd_q     <= 1'b1;
                rw_q     <= 1'b1;
                oe_q     <= 1'b0;
                rs_q     <= 1'b0;
                poll_cnt <= '0;
                state    <= ST_SETUP;
              end else if (pbusy_q) begin
                state <= ST_SETUP;
              end else begin
                rd_q    <= 1'b0;
                rw_q    <= 1'b0;
                oe_q    <= 1'b1;
                ready_q <= 1'b1;
                state   <= ST_IDLE;
              end
`else
              state <= ST_WAIT;
`endif
            end
          end
        end
        ST_WAIT: begin
          if (t_done) begin
            ready_q <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
